bitwise_shifter: RTL and testbench

BITWISE_SHIFTER -- requirements
Module: bitwise_shifter

---
 rtl/bitwise_pkg.sv | 16 +
 rtl/bitwise_step.sv | 46 ++++
 rtl/bitwise_shifter.sv | 114 +++++++++++
 tb/tb_bitwise_shifter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise shifter: step-mode encodings and FSM states.
package bitwise_pkg;

  localparam logic [2:0] MODE_SHL = 3'd0;
  localparam logic [2:0] MODE_SHR = 3'd1;
  localparam logic [2:0] MODE_ROL = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ASR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_step.sv
// Combinational single-step datapath: computes the next register value and the
// bit that leaves the register for one shift/rotate step.
module bitwise_step
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             d,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit,
  output logic             valid_mode
);

  always_comb begin
    next_q     = q;
    out_bit    = 1'b0;
    valid_mode = 1'b1;
    case (mode)
      MODE_SHL: begin
        next_q  = {q[WIDTH-2:0], d};
        out_bit = q[WIDTH-1];
      end
      MODE_SHR: begin
        next_q  = {d, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      MODE_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ASR: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      // Reserved encodings leave the register and shift_out untouched.
      default: valid_mode = 1'b0;
    endcase
  end

endmodule

// File: rtl/bitwise_shifter.sv
// Shift/rotate register with parallel load, single-step mode and a counted
// multi-step operation controlled by an IDLE/SHIFT/DONE state machine.
module bitwise_shifter
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load,
  input  logic             load_en,
  input  logic             en,
  input  logic             d,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2:0]       mode_reg, mode_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             shift_out_reg, shift_out_next;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  logic             step_valid;

  // Multi-step operations use the mode captured at start; single steps use the live input.
  assign step_mode = (state_reg == ST_SHIFT) ? mode_reg : mode;

  bitwise_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q         (q_reg),
    .mode      (step_mode),
    .d         (d),
    .next_q    (step_q),
    .out_bit   (step_bit),
    .valid_mode(step_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      mode_reg      <= MODE_SHL;
      q_reg         <= '0;
      shift_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      mode_reg      <= mode_next;
      q_reg         <= q_next;
      shift_out_reg <= shift_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    mode_next      = mode_reg;
    q_next         = q_reg;
    shift_out_next = shift_out_reg;

    if (load_en) begin
      q_next     = load;
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mode_next  = mode;
            count_next = amount;
            state_next = (amount != '0) ? ST_SHIFT : ST_DONE;
          end else if (en && step_valid) begin
            q_next         = step_q;
            shift_out_next = step_bit;
          end
        end
        ST_SHIFT: begin
          if (step_valid) begin
            q_next         = step_q;
            shift_out_next = step_bit;
          end
          count_next = count_reg - 1'b1;
          if (count_reg == CNT_W'(1)) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  assign q         = q_reg;
  assign shift_out = shift_out_reg;
  assign busy      = (state_reg == ST_SHIFT);
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_bitwise_shifter.sv
// Self-checking bench for bitwise_shifter (WIDTH=8): vector table, directed
// multi-cycle sequences and a randomized run against an arithmetic model.
module tb_bitwise_shifter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] load = '0;
  logic             load_en = 1'b0;
  logic             en = 1'b0;
  logic             d = 1'b0;
  logic [2:0]       mode = 3'd0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] amount = '0;
  logic [WIDTH-1:0] q;
  logic             shift_out;
  logic             busy;
  logic             done;

  int total_checks = 0;
  int passed_checks = 0;

  always #5 clk = ~clk;

  bitwise_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_en  (load_en),
    .en       (en),
    .d        (d),
    .mode     (mode),
    .start    (start),
    .amount   (amount),
    .q        (q),
    .shift_out(shift_out),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [7:0] init;
    logic [2:0] mode;
    logic       d;
    logic [7:0] exp_q;
    logic       exp_so;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) begin
      passed_checks++;
      $display("check %-18s actual=0x%0h expected=0x%0h ok", name, actual, expected);
    end else begin
      $display("FAIL %-18s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_en = 1'b1;
    load = v;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] m, input int n);
    start = 1'b1;
    mode = m;
    amount = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  // Reference model: register kept as an integer 0..255, steps by plain arithmetic.
  int m_q, m_so, m_left, m_done, m_mode;

  function automatic void model_step(input int md, input int din);
    int nq;
    nq = m_q;
    case (md)
      0: begin nq = (m_q * 2 + din) % 256;        m_so = m_q / 128; end
      1: begin nq = m_q / 2 + din * 128;          m_so = m_q % 2;   end
      2: begin nq = (m_q * 2) % 256 + m_q / 128;  m_so = m_q / 128; end
      3: begin nq = m_q / 2 + (m_q % 2) * 128;    m_so = m_q % 2;   end
      4: begin nq = m_q / 2 + (m_q / 128) * 128;  m_so = m_q % 2;   end
      default: ;
    endcase
    m_q = nq;
  endfunction

  function automatic void model_edge();
    if (reset) begin
      m_q = 0; m_so = 0; m_left = 0; m_done = 0;
    end else if (load_en) begin
      m_q = int'(load); m_left = 0; m_done = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_left > 0) begin
      model_step(m_mode, int'(d));
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (start) begin
      m_mode = int'(mode);
      if (amount == 0) m_done = 1;
      else m_left = int'(amount);
    end else if (en) begin
      model_step(int'(mode), int'(d));
    end
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'hA5, 3'd0, 1'b0, 8'h4A, 1'b1};
    vecs[1] = '{8'hA5, 3'd0, 1'b1, 8'h4B, 1'b1};
    vecs[2] = '{8'hA5, 3'd1, 1'b1, 8'hD2, 1'b1};
    vecs[3] = '{8'h5A, 3'd1, 1'b0, 8'h2D, 1'b0};
    vecs[4] = '{8'h81, 3'd2, 1'b0, 8'h03, 1'b1};
    vecs[5] = '{8'h81, 3'd3, 1'b0, 8'hC0, 1'b1};
    vecs[6] = '{8'h80, 3'd4, 1'b0, 8'hC0, 1'b0};
    vecs[7] = '{8'h41, 3'd4, 1'b1, 8'h20, 1'b1};
    // Reserved modes hold both q and the previous shift_out.
    vecs[8] = '{8'h3C, 3'd5, 1'b1, 8'h3C, 1'b1};
    vecs[9] = '{8'hF0, 3'd7, 1'b0, 8'hF0, 1'b1};

    // Reset clears a preloaded register.
    tick();
    do_load(8'h80);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_so", shift_out, 0);

    // Single-step vector table.
    foreach (vecs[i]) begin
      do_load(vecs[i].init);
      en = 1'b1; mode = vecs[i].mode; d = vecs[i].d;
      tick();
      en = 1'b0;
      check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_so", i), shift_out, vecs[i].exp_so);
      check($sformatf("vec%0d_done", i), done, 0);
    end

    // Multi-step rotate left by 3 from 0xA5.
    do_load(8'hA5);
    do_start(3'd2, 3);
    check("rol_busy0", busy, 1);
    check("rol_q0", q, 8'hA5);
    mode = 3'd1;
    tick(); check("rol_q1", q, 8'h4B); check("rol_busy1", busy, 1);
    tick(); check("rol_q2", q, 8'h96); check("rol_busy2", busy, 1);
    tick(); check("rol_q3", q, 8'h2D); check("rol_busy3", busy, 0);
    check("rol_done", done, 1);
    check("rol_so", shift_out, 1);
    tick(); check("rol_done_clr", done, 0);

    // Arithmetic shift then a zero-length operation.
    do_load(8'h80);
    d = 1'b1;
    do_start(3'd4, 2);
    tick(); tick();
    check("asr_q", q, 8'hE0);
    check("asr_so", shift_out, 0);
    check("asr_done", done, 1);
    tick();
    do_start(3'd0, 0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_q", q, 8'hE0);
    tick();
    check("zero_done_clr", done, 0);

    // Single steps with en from zero.
    reset = 1'b1; tick(); reset = 1'b0;
    en = 1'b1; mode = 3'd0; d = 1'b1;
    tick(); check("en_done1", done, 0);
    tick(); check("en_done2", done, 0);
    en = 1'b0;
    check("en_q", q, 8'h03);
    check("en_so", shift_out, 0);

    // Abort an in-progress rotate with load_en.
    do_load(8'h01);
    do_start(3'd3, 5);
    tick(); tick();
    check("abort_pre_q", q, 8'h40);
    do_load(8'h0F);
    check("abort_q", q, 8'h0F);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_nodone", done, 0);
    end

    // Reset in the middle of a multi-step operation.
    do_load(8'h5A);
    do_start(3'd2, 4);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_mid_q", q, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    tick();
    check("rst_mid_nodone", done, 0);

    // Randomized run against the arithmetic model, starting from a clean reset.
    reset = 1'b1;
    model_edge();
    tick();
    reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 59) == 0);
      load_en = ($urandom_range(0, 19) == 0);
      start   = ($urandom_range(0, 5) == 0);
      en      = $urandom_range(0, 1) != 0;
      d       = $urandom_range(0, 1) != 0;
      mode    = 3'($urandom_range(0, 7));
      amount  = CNT_W'($urandom_range(0, 9));
      load    = 8'($urandom_range(0, 255));
      model_edge();
      tick();
      check("rnd_q", q, m_q);
      check("rnd_so", shift_out, m_so);
      check("rnd_busy", busy, (m_left > 0) ? 1 : 0);
      check("rnd_done", done, m_done);
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
